// File: rtl/alu_pkg.sv
// Shared CPU types for the execute-stage ALU: operation codes, flag indices and
// operand/result bundles.
package pkg_cpu;

  localparam int unsigned XLEN = 32;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpAdc = 4'd1,
    OpSub = 4'd2,
    OpSbc = 4'd3,
    OpRsb = 4'd4,
    OpMul = 4'd5,
    OpAnd = 4'd6,
    OpOrr = 4'd7,
    OpXor = 4'd8,
    OpBic = 4'd9,
    OpLsl = 4'd10,
    OpLsr = 4'd11,
    OpAsr = 4'd12,
    OpRol = 4'd13,
    OpRor = 4'd14,
    OpCpy = 4'd15
  } AluOper;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    AluOper          oper;
    logic [3:0]      flags;
  } StrcInAlu;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [3:0]      flags;
  } StrcOutAlu;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the CPU control FSM (master) and the ALU (slave).
interface alu_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       oper;
  logic [3:0]       flags_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_out;

  modport master (
    output in_valid, a, b, oper, flags_in,
    input  out_valid, result, flags_out
  );

  modport slave (
    input  in_valid, a, b, oper, flags_in,
    output out_valid, result, flags_out
  );

endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for LSL/LSR/ASR/ROL/ROR with carry-out of the last
// bit shifted or rotated out. WIDTH must be a power of two.
module alu_shifter
  import pkg_cpu::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  AluOper           oper_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] shift_o,
  output logic             carry_o
);

  localparam int unsigned      IdxW   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WidthV = WIDTH;

  logic            amt_zero;
  logic            amt_below;
  logic            amt_at_width;
  logic [IdxW-1:0] amt;
  logic [IdxW-1:0] amt_m1;
  logic [IdxW-1:0] amt_neg;

  assign amt_zero     = (b_i == '0);
  assign amt_below    = (b_i < WidthV);
  assign amt_at_width = (b_i == WidthV);
  // Low bits are the shift amount when below WIDTH and always equal b % WIDTH.
  assign amt          = b_i[IdxW-1:0];
  assign amt_m1       = amt - 1'b1;
  assign amt_neg      = ~amt + 1'b1;

  always_comb begin
    shift_o = a_i;
    carry_o = carry_i;
    case (oper_i)
      OpLsl: begin
        if (!amt_zero) begin
          if (amt_below) begin
            shift_o = a_i << amt;
            carry_o = a_i[amt_neg];
          end else begin
            shift_o = '0;
            carry_o = amt_at_width ? a_i[0] : 1'b0;
          end
        end
      end
      OpLsr: begin
        if (!amt_zero) begin
          if (amt_below) begin
            shift_o = a_i >> amt;
            carry_o = a_i[amt_m1];
          end else begin
            shift_o = '0;
            carry_o = amt_at_width ? a_i[WIDTH-1] : 1'b0;
          end
        end
      end
      OpAsr: begin
        if (!amt_zero) begin
          if (amt_below) begin
            shift_o = $signed(a_i) >>> amt;
            carry_o = a_i[amt_m1];
          end else begin
            shift_o = {WIDTH{a_i[WIDTH-1]}};
            carry_o = a_i[WIDTH-1];
          end
        end
      end
      OpRol: begin
        if (amt != '0) begin
          shift_o = (a_i << amt) | (a_i >> amt_neg);
          carry_o = shift_o[0];
        end
      end
      OpRor: begin
        if (amt != '0) begin
          shift_o = (a_i >> amt) | (a_i << amt_neg);
          carry_o = shift_o[WIDTH-1];
        end
      end
      default: begin
        shift_o = a_i;
        carry_o = carry_i;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU for the CPU execute stage: one-cycle latency, one op per cycle,
// producing result plus updated Z/C/V/N flags.
module alu
  import pkg_cpu::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  AluOper           op;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul;
  logic [WIDTH-1:0] shift_res;
  logic             shift_c;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d, flags_q;

  logic unused_flags;
  assign unused_flags = ^{bus.flags_in[FLAG_Z], bus.flags_in[FLAG_N]};

  assign op = AluOper'(bus.oper);

  // All add/sub variants share one adder; subtraction feeds the inverted operand.
  always_comb begin
    add_x   = bus.a;
    add_y   = bus.b;
    add_cin = 1'b0;
    case (op)
      OpAdc: add_cin = bus.flags_in[FLAG_C];
      OpSub: begin
        add_y   = ~bus.b;
        add_cin = 1'b1;
      end
      OpSbc: begin
        add_y   = ~bus.b;
        add_cin = bus.flags_in[FLAG_C];
      end
      OpRsb: begin
        add_x   = bus.b;
        add_y   = ~bus.a;
        add_cin = 1'b1;
      end
      default: add_cin = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign mul = bus.a * bus.b;

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .a_i     (bus.a),
    .b_i     (bus.b),
    .oper_i  (op),
    .carry_i (bus.flags_in[FLAG_C]),
    .shift_o (shift_res),
    .carry_o (shift_c)
  );

  always_comb begin
    alu_res = bus.b;
    alu_c   = bus.flags_in[FLAG_C];
    alu_v   = bus.flags_in[FLAG_V];
    case (op)
      OpAdd, OpAdc, OpSub, OpSbc, OpRsb: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      OpMul: alu_res = mul;
      OpAnd: alu_res = bus.a & bus.b;
      OpOrr: alu_res = bus.a | bus.b;
      OpXor: alu_res = bus.a ^ bus.b;
      OpBic: alu_res = bus.a & ~bus.b;
      OpLsl, OpLsr, OpAsr, OpRol, OpRor: begin
        alu_res = shift_res;
        alu_c   = shift_c;
      end
      default: alu_res = bus.b;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
  end

  always_comb begin
    valid_d  = bus.in_valid;
    result_d = bus.in_valid ? alu_res : result_q;
    flags_d  = bus.in_valid ? alu_flags : flags_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the ALU against an arithmetic reference model.
module tb_alu;
  import pkg_cpu::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(XLEN)) bus ();

  alu #(.WIDTH(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int        checks = 0;
  int        errors = 0;
  StrcOutAlu last;

  function automatic StrcOutAlu ref_alu(input StrcInAlu in);
    StrcOutAlu              o;
    longint                 sa, sb, ci, s;
    logic [63:0]            w;
    logic signed [63:0]     ws;
    logic [XLEN-1:0]        r;
    logic                   cf, vf, arith;
    int unsigned            n;
    sa    = longint'($signed(in.a));
    sb    = longint'($signed(in.b));
    ci    = in.flags[FLAG_C] ? 64'sd1 : 64'sd0;
    cf    = in.flags[FLAG_C];
    vf    = in.flags[FLAG_V];
    r     = in.b;
    s     = 0;
    arith = 1'b0;
    case (in.oper)
      OpAdd: begin
        w = {32'b0, in.a} + {32'b0, in.b}; r = w[31:0]; cf = w[32]; s = sa + sb; arith = 1;
      end
      OpAdc: begin
        w = {32'b0, in.a} + {32'b0, in.b} + {63'b0, in.flags[FLAG_C]};
        r = w[31:0]; cf = w[32]; s = sa + sb + ci; arith = 1;
      end
      OpSub: begin r = in.a - in.b; cf = (in.a >= in.b); s = sa - sb; arith = 1; end
      OpSbc: begin
        r  = in.a - in.b - 32'(1 - ci);
        cf = ({32'b0, in.a} + {63'b0, in.flags[FLAG_C]}) >= ({32'b0, in.b} + 64'd1);
        s  = sa - sb - 1 + ci; arith = 1;
      end
      OpRsb: begin r = in.b - in.a; cf = (in.b >= in.a); s = sb - sa; arith = 1; end
      OpMul: begin w = {32'b0, in.a} * {32'b0, in.b}; r = w[31:0]; end
      OpAnd: r = in.a & in.b;
      OpOrr: r = in.a | in.b;
      OpXor: r = in.a ^ in.b;
      OpBic: r = in.a & ~in.b;
      OpLsl: begin
        r = in.a;
        if (in.b != 0 && in.b <= 32) begin
          w = {32'b0, in.a} << in.b; r = w[31:0]; cf = w[32];
        end else if (in.b > 32) begin r = 0; cf = 0; end
      end
      OpLsr: begin
        r = in.a;
        if (in.b != 0 && in.b <= 32) begin
          w = {in.a, 32'b0} >> in.b; r = w[63:32]; cf = w[31];
        end else if (in.b > 32) begin r = 0; cf = 0; end
      end
      OpAsr: begin
        r = in.a;
        if (in.b >= 32) begin
          r = {32{in.a[31]}}; cf = in.a[31];
        end else if (in.b != 0) begin
          ws = {in.a, 32'b0}; ws = ws >>> in.b; r = ws[63:32]; cf = ws[31];
        end
      end
      OpRol: begin
        r = in.a; n = in.b % 32;
        for (int i = 0; i < int'(n); i++) begin cf = r[31]; r = {r[30:0], r[31]}; end
      end
      OpRor: begin
        r = in.a; n = in.b % 32;
        for (int i = 0; i < int'(n); i++) begin cf = r[0]; r = {r[0], r[31:1]}; end
      end
      default: r = in.b;
    endcase
    // Signed overflow: true mathematical result not representable in XLEN bits.
    if (arith) vf = (s != longint'($signed(r)));
    o.result        = r;
    o.flags         = '0;
    o.flags[FLAG_Z] = (r == 0);
    o.flags[FLAG_C] = cf;
    o.flags[FLAG_V] = vf;
    o.flags[FLAG_N] = r[31];
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input AluOper op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [3:0] fv);
    @(negedge clk);
    bus.in_valid = v;
    bus.oper     = op;
    bus.a        = av;
    bus.b        = bv;
    bus.flags_in = fv;
  endtask

  task automatic sample(input string tag, input logic v, input logic [31:0] r,
                        input logic [3:0] f);
    @(posedge clk);
    #1;
    check({tag, ".vld"}, {31'b0, bus.out_valid}, {31'b0, v});
    check({tag, ".res"}, bus.result, r);
    check({tag, ".flg"}, {28'b0, bus.flags_out}, {28'b0, f});
  endtask

  task automatic directed(input string tag, input AluOper op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [3:0] fv,
                          input logic [31:0] er, input logic [3:0] ef);
    drive(1'b1, op, av, bv, fv);
    sample(tag, 1'b1, er, ef);
    last.result = er;
    last.flags  = ef;
  endtask

  initial begin
    StrcInAlu  in;
    StrcOutAlu exp;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.oper     = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.flags_in = '0;
    @(posedge clk);
    sample("reset", 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flags nibble is {N, V, C, Z}; consecutive ops exercise back-to-back throughput.
    directed("add_ovf", OpAdd, 32'h7FFF_FFFF, 32'h1, 4'h0, 32'h8000_0000, 4'hC);
    directed("sub_eq",  OpSub, 32'd5, 32'd5, 4'h0, 32'h0, 4'h3);
    directed("sbc_00",  OpSbc, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFFF, 4'h8);
    directed("lsl_1",   OpLsl, 32'h8000_0001, 32'd1, 4'h0, 32'h2, 4'h2);
    directed("asr_40",  OpAsr, 32'h8000_0000, 32'd40, 4'h0, 32'hFFFF_FFFF, 4'hA);
    directed("lsr_0",   OpLsr, 32'h1234_5678, 32'd0, 4'h2, 32'h1234_5678, 4'h2);
    directed("ror_33",  OpRor, 32'h1, 32'd33, 4'h0, 32'h8000_0000, 4'hA);
    directed("and_z",   OpAnd, 32'hF0, 32'h0F, 4'h6, 32'h0, 4'h7);
    directed("mul_z",   OpMul, 32'h1_0000, 32'h1_0000, 4'h6, 32'h0, 4'h7);

    drive(1'b0, OpCpy, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hF);
    sample("hold", 1'b0, last.result, last.flags);

    for (int i = 0; i < 400; i++) begin
      in.oper  = AluOper'($urandom_range(0, 15));
      in.a     = $urandom();
      in.b     = ($urandom_range(0, 2) == 0) ? $urandom() : $urandom_range(0, 40);
      in.flags = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) in.a = {$urandom_range(0, 1) == 1, 31'h7FFF_FFFF};
      exp = ref_alu(in);
      drive(1'b1, in.oper, in.a, in.b, in.flags);
      sample($sformatf("rnd%0d_op%0d", i, in.oper), 1'b1, exp.result, exp.flags);
      last = exp;
      if (i % 23 == 11) begin
        drive(1'b0, AluOper'($urandom_range(0, 15)), $urandom(), $urandom(), 4'hF);
        sample($sformatf("idle%0d", i), 1'b0, last.result, last.flags);
      end
    end

    drive(1'b1, OpAdd, 32'h1, 32'h1, 4'hF);
    rst_n = 1'b0;
    sample("rst_vld", 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    sample("post_rst", 1'b0, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit arithmetic/logic unit for the CPU execute stage. It accepts two operands, a 4-bit operation code and the current flags. One cycle later it returns the result and the updated flags (Z, C, V, N). The CPU control FSM drives it and commits `result`/`flags_out` to the GPRs and the flags register during writeback.

## Interface
- Clock and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `WIDTH`, default 32: operand/result width; flag rules below reference bit `WIDTH-1`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  operands/op valid this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (shift/rotate amount for shift ops).
- `oper`  in  4  operation code.
- `flags_in`  in  4  current flags: [0]=Z, [1]=C, [2]=V, [3]=N.
- `out_valid`  out  1  result valid.
- `result`  out  WIDTH  registered result.
- `flags_out`  out  4  registered flags, same bit order as `flags_in`.

## Operation
Operation codes:
- 0 ADD: a+b.
- 1 ADC: a+b+C.
- 2 SUB: a−b, computed as a+~b+1.
- 3 SBC: a+~b+C.
- 4 RSB: b−a.
- 5 MUL: low WIDTH bits of a*b.
- 6 AND; 7 ORR; 8 XOR; 9 BIC (a&~b).
- 10 LSL; 11 LSR; 12 ASR.
- 13 ROL; 14 ROR.
- 15 CPY: result = b.

Shift amount:
- LSL/LSR/ASR use the full unsigned `b`.
- For amounts ≥ WIDTH, LSL/LSR give 0 and ASR gives all copies of a[WIDTH-1].
- ROL/ROR use `b % WIDTH`.

Flags, for every op:
- N = result[WIDTH-1].
- Z = (result == 0).

Flags for add/sub ops (0–4):
- C = carry out of the WIDTH-bit addition. For subtraction this means C=1 when there is no borrow.
- V = signed overflow: operand signs of the effective addends equal and the result sign differs.

Flags for shift/rotate ops (10–14):
- C = last bit shifted or rotated out.
- LSL/LSR with amount > WIDTH: C=0.
- ASR with amount ≥ WIDTH: C = a[WIDTH-1].
- Amount 0: C = flags_in[1].
- V = flags_in[2].

Flags for MUL, logical ops and CPY:
- C = flags_in[1].
- V = flags_in[2].

## Timing
- Latency is exactly 1 cycle. Inputs sampled at the `clk` edge with `in_valid`=1 appear on `result`/`flags_out` after that edge, with `out_valid`=1.
- Throughput is one op per cycle; back-to-back `in_valid` gives back-to-back results.
- `in_valid`=0: `out_valid` goes to 0 on the next edge; `result` and `flags_out` hold their previous values.
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `result`=0, `flags_out`=0. Reset overrides a simultaneous `in_valid`.
- Reset while an op is in flight: the op is dropped and no `out_valid` pulse is produced.
- No backpressure; the consumer must capture the result on the cycle `out_valid`=1.

## Structure
- The shared package `pkg_cpu` holds:
  - the `AluOper` 4-bit enum (codes above);
  - flag index constants `FLAG_Z`=0, `FLAG_C`=1, `FLAG_V`=2, `FLAG_N`=3;
  - packed structs `StrcInAlu {a, b, oper, flags}` and `StrcOutAlu {result, flags}`.
- One sub-module is natural: `alu_shifter`. It is a combinational barrel shifter for LSL/LSR/ASR/ROL/ROR that outputs the shifted value and the carry-out bit.
- Adder, logic and MUL paths stay inline. The combinational result and flags feed a single output register stage.

## Test plan
- ADD overflow: a=0x7FFFFFFF, b=1, flags_in=0 → result 0x80000000, N=1 Z=0 C=0 V=1, `out_valid` one cycle after `in_valid`.
- SUB equal: a=5, b=5 → result 0, Z=1 C=1 N=0 V=0. Then SBC a=0, b=0, C=0 → result 0xFFFFFFFF, N=1 C=0.
- Shifts:
  - LSL a=0x80000001, b=1 → result 0x00000002, C=1.
  - ASR a=0x80000000, b=40 → result 0xFFFFFFFF, C=1.
  - LSR with b=0 and flags_in C=1 → result = a, C=1.
- ROR a=0x00000001, b=33 → result 0x80000000, C=1, N=1.
- Logic/MUL flag preservation: flags_in C=1 V=1. AND a=0xF0, b=0x0F → result 0, Z=1 C=1 V=1. MUL a=0x10000, b=0x10000 → result 0, Z=1.
- Control:
  - back-to-back ops on consecutive cycles each return one cycle later;
  - `in_valid`=0 holds `result`;
  - `rst_n`=0 together with `in_valid`=1 → `out_valid`=0, `result`=0, `flags_out`=0 on the next cycle.
